mul_unit: RTL



---
 rtl/mul_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - iterative radix-2 shift-add 64-bit multiplier (MUL/UMULH/SMULH) feeding the register file write port
// Optional feature macro: SIGNED_MUL_EN (SMULH magnitude/negate path; when undefined Op=10 executes as UMULH)
module mul_unit #(
    parameter int BITSIZE = 64,
    parameter int REGSIZE = 32,
    localparam int IDXW   = $clog2(REGSIZE),
    localparam int CNTW   = $clog2(BITSIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          Op,
    input  logic [BITSIZE-1:0]  OperandA,
    input  logic [BITSIZE-1:0]  OperandB,
    input  logic [IDXW-1:0]     DestSelect,
    output logic                busy,
    output logic                done,
    output logic [BITSIZE-1:0]  Result,
    output logic [IDXW-1:0]     ResultSelect,
    output logic                WriteEnable
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0]           OP_UMULH = 2'b01;
    localparam logic [1:0]           OP_SMULH = 2'b10;
    localparam logic [IDXW-1:0]      ZERO_REG = IDXW'(REGSIZE - 1);
    localparam logic [CNTW-1:0]      LAST_CNT = CNTW'(BITSIZE - 1);

    state_t                 state_q;
    logic [1:0]             op_q;
    logic [IDXW-1:0]        dest_q;
    logic [BITSIZE-1:0]     mcand_q;
    logic [2*BITSIZE-1:0]   acc_q;
    logic [CNTW-1:0]        cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   we_q;
    logic [BITSIZE-1:0]     result_q;
    logic [IDXW-1:0]        ressel_q;

    logic                   accept;
    logic [BITSIZE-1:0]     mcand_d;
    logic [BITSIZE-1:0]     mplier_d;
    logic [BITSIZE:0]       sum;
    logic [2*BITSIZE-1:0]   acc_step;
    logic [2*BITSIZE-1:0]   acc_fixed;
    logic                   sel_high;
    logic [BITSIZE-1:0]     result_d;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef SIGNED_MUL_EN
    localparam logic [BITSIZE-1:0]   ONE_B   = BITSIZE'(1);
    localparam logic [2*BITSIZE-1:0] ONE_ACC = (2*BITSIZE)'(1);

    logic                   neg_q;
    logic                   neg_d;
    logic                   is_smulh;

    // Magnitudes are held unsigned, so 0x8000..0 maps onto 2^(BITSIZE-1) without overflow.
    assign is_smulh  = (Op == OP_SMULH);
    assign mcand_d   = (is_smulh && OperandA[BITSIZE-1]) ? (~OperandA + ONE_B) : OperandA;
    assign mplier_d  = (is_smulh && OperandB[BITSIZE-1]) ? (~OperandB + ONE_B) : OperandB;
    assign neg_d     = is_smulh && (OperandA[BITSIZE-1] ^ OperandB[BITSIZE-1]);
    assign acc_fixed = neg_q ? (~acc_q + ONE_ACC) : acc_q;
`else
    assign mcand_d   = OperandA;
    assign mplier_d  = OperandB;
    assign acc_fixed = acc_q;
`endif

    // Multiplier lives in the low half and is consumed one bit per shift.
    assign sum      = {1'b0, acc_q[2*BITSIZE-1:BITSIZE]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {sum, acc_q[BITSIZE-1:1]};

    assign sel_high = (op_q == OP_UMULH) || (op_q == OP_SMULH);
    assign result_d = sel_high ? acc_fixed[2*BITSIZE-1:BITSIZE] : acc_fixed[BITSIZE-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            dest_q   <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            result_q <= '0;
            ressel_q <= '0;
`ifdef SIGNED_MUL_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q    <= Op;
                        dest_q  <= DestSelect;
                        mcand_q <= mcand_d;
                        acc_q   <= {{BITSIZE{1'b0}}, mplier_d};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef SIGNED_MUL_EN
                        neg_q   <= neg_d;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // Outputs are registered here so they are valid for the whole DONE cycle.
                    acc_q    <= acc_fixed;
                    result_q <= result_d;
                    ressel_q <= dest_q;
                    done_q   <= 1'b1;
                    we_q     <= (dest_q != ZERO_REG);
                    busy_q   <= 1'b0;
                    state_q  <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign WriteEnable  = we_q;
    assign Result       = result_q;
    assign ResultSelect = ressel_q;

endmodule
